// File: rtl/sprite_line_scheduler_pkg.sv
// Shared types and constants for the per-scanline sprite scheduler.
package sprite_sched_pkg;

  localparam int NUM_SPRITES = 20;
  localparam int MAX_ACTIVE  = 8;
  localparam int SPRITE_H    = 32;
  localparam int V_ACTIVE    = 480;
  localparam int V_TOTAL     = 525;

  localparam int ENTRY_W = 24;
  localparam int TABLE_W = 512;
  localparam int IDX_W   = 5;   // holds 0..NUM_SPRITES-1
  localparam int CNT_W   = 4;   // holds 0..MAX_ACTIVE

  // One sprite table entry as written by the CPU; id 0 disables the entry.
  typedef struct packed {
    logic [3:0] id;
    logic [9:0] x;
    logic [9:0] y;
  } sprite_entry_t;

  // One published slot: which sprite, where it starts, which row to fetch.
  typedef struct packed {
    logic [3:0] id;
    logic [9:0] x;
    logic [4:0] row;
  } slot_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PUBLISH = 2'd2
  } sched_state_t;

  // Line that follows vcount, wrapping at the end of the frame.
  function automatic logic [9:0] next_line(input logic [9:0] vcount);
    if (vcount == 10'(V_TOTAL - 1)) return 10'd0;
    return vcount + 10'd1;
  endfunction

  // Thermometer mask with the low cnt bits set: (1 << cnt) - 1.
  function automatic logic [MAX_ACTIVE-1:0] valid_mask(input logic [CNT_W-1:0] cnt);
    logic [MAX_ACTIVE:0] one_hot;
    logic [MAX_ACTIVE:0] mask;
    one_hot = (MAX_ACTIVE + 1)'(1) << cnt;
    mask    = one_hot - (MAX_ACTIVE + 1)'(1);
    return mask[MAX_ACTIVE-1:0];
  endfunction

endpackage

// File: rtl/sprite_line_scheduler_hit_test.sv
// Combinational test of one sprite entry against a target display line.
module sprite_hit_test
  import sprite_sched_pkg::*;
(
  input  sprite_entry_t entry,
  input  logic [9:0]    target,
  output logic          hit,
  output logic [4:0]    row
);

  logic [10:0] diff;

  // Sprite covers lines y..y+SPRITE_H-1; the 11-bit difference never wraps
  // across the frame top because y <= target is required separately.
  always_comb begin
    diff = {1'b0, target} - {1'b0, entry.y};
    hit  = (entry.id != 4'd0) && (entry.y <= target) && (diff < 11'(SPRITE_H));
    row  = diff[4:0];
  end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: shadows the CPU sprite table, commits it at
// vertical blank, and in each horizontal blank builds the slot list for the
// next display line.
module sprite_line_scheduler
  import sprite_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [TABLE_W-1:0]      gl_input,
  input  logic                    write,
  input  logic [9:0]              vcount,
  input  logic                    hblank_start,
  input  logic                    vblank_start,
  output logic [MAX_ACTIVE-1:0]   slot_valid,
  output logic [4*MAX_ACTIVE-1:0] slot_id,
  output logic [10*MAX_ACTIVE-1:0] slot_x,
  output logic [5*MAX_ACTIVE-1:0] slot_row,
  output logic                    list_ready,
  output logic                    overflow,
  output logic                    busy
);

  sched_state_t  state_q, state_d;
  sprite_entry_t pend_q [NUM_SPRITES];
  sprite_entry_t pend_d [NUM_SPRITES];
  sprite_entry_t live_q [NUM_SPRITES];
  sprite_entry_t live_d [NUM_SPRITES];
  logic          pending_q, pending_d;
  logic          commit_req_q, commit_req_d;

  logic [9:0]       target_q, target_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_t            work_q [MAX_ACTIVE];
  slot_t            work_d [MAX_ACTIVE];
  logic             work_ovf_q, work_ovf_d;

  slot_t                 out_slot_q [MAX_ACTIVE];
  slot_t                 out_slot_d [MAX_ACTIVE];
  logic [MAX_ACTIVE-1:0] out_valid_q, out_valid_d;
  logic                  out_ovf_q, out_ovf_d;
  logic                  list_ready_q, list_ready_d;

  sprite_entry_t gl_entries [NUM_SPRITES];
  sprite_entry_t scan_entry;
  logic          hit;
  logic [4:0]    hit_row;
  logic          commit;

  // The top word of the table bus carries no entries.
  logic unused_hi;
  assign unused_hi = ^gl_input[TABLE_W-1:NUM_SPRITES*ENTRY_W];

  // Slice the packed table bus into entries.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      gl_entries[i] = sprite_entry_t'(gl_input[ENTRY_W*i +: ENTRY_W]);
    end
  end

  assign scan_entry = live_q[idx_q];

  sprite_hit_test u_hit_test (
    .entry  (scan_entry),
    .target (target_q),
    .hit    (hit),
    .row    (hit_row)
  );

  // Next-state logic for the table shadowing and the scan FSM.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case/if tree leaves it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    pend_d       = pend_q;
    live_d       = live_q;
    pending_d    = pending_q;
    commit_req_d = commit_req_q;
    target_d     = target_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    work_d       = work_q;
    work_ovf_d   = work_ovf_q;
    out_slot_d   = out_slot_q;
    out_valid_d  = out_valid_q;
    out_ovf_d    = out_ovf_q;
    list_ready_d = 1'b0;

    // Commit only from IDLE so a scan always sees one consistent table.
    commit = (state_q == IDLE) && commit_req_q;
    if (commit) begin
      live_d       = pend_q;
      pending_d    = 1'b0;
      commit_req_d = 1'b0;
    end
    // A write in the commit cycle lands after the copy and re-arms pending.
    if (write) begin
      pend_d    = gl_entries;
      pending_d = 1'b1;
    end
    if (vblank_start && pending_q && !commit) begin
      commit_req_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hblank_start) begin
          target_d   = next_line(vcount);
          idx_d      = '0;
          cnt_d      = '0;
          work_ovf_d = 1'b0;
          work_d     = '{default: '0};
          // Lines in vertical blank have nothing to draw.
          state_d    = (target_d >= 10'(V_ACTIVE)) ? PUBLISH : SCAN;
        end
      end

      SCAN: begin
        if (hit) begin
          if (cnt_q < CNT_W'(MAX_ACTIVE)) begin
            work_d[cnt_q[2:0]] = '{id: scan_entry.id, x: scan_entry.x, row: hit_row};
            cnt_d              = cnt_q + CNT_W'(1);
          end else begin
            work_ovf_d = 1'b1;
          end
        end
        if (idx_q == IDX_W'(NUM_SPRITES - 1)) begin
          state_d = PUBLISH;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      PUBLISH: begin
        out_slot_d   = work_q;
        out_valid_d  = valid_mask(cnt_q);
        out_ovf_d    = work_ovf_q;
        list_ready_d = 1'b1;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight scan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      // NOTE: both tables are reset because an all-zero table is the defined
      // "every sprite disabled" state; plain storage arrays normally are not.
      pend_q       <= '{default: '0};
      live_q       <= '{default: '0};
      pending_q    <= 1'b0;
      commit_req_q <= 1'b0;
      target_q     <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      work_q       <= '{default: '0};
      work_ovf_q   <= 1'b0;
      out_slot_q   <= '{default: '0};
      out_valid_q  <= '0;
      out_ovf_q    <= 1'b0;
      list_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values of the previous cycle regardless of statement order.
      state_q      <= state_d;
      pend_q       <= pend_d;
      live_q       <= live_d;
      pending_q    <= pending_d;
      commit_req_q <= commit_req_d;
      target_q     <= target_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      work_q       <= work_d;
      work_ovf_q   <= work_ovf_d;
      out_slot_q   <= out_slot_d;
      out_valid_q  <= out_valid_d;
      out_ovf_q    <= out_ovf_d;
      list_ready_q <= list_ready_d;
    end
  end

  // Flatten the published slots onto the output buses.
  for (genvar k = 0; k < MAX_ACTIVE; k++) begin : g_out
    assign slot_id[4*k +: 4]   = out_slot_q[k].id;
    assign slot_x[10*k +: 10]  = out_slot_q[k].x;
    assign slot_row[5*k +: 5]  = out_slot_q[k].row;
  end

  assign slot_valid = out_valid_q;
  assign overflow   = out_ovf_q;
  assign list_ready = list_ready_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/sprite_line_scheduler.md
# sprite_line_scheduler

Per-scanline sprite scheduler between the CPU-written sprite table and the sprite controller. It shadows the 20-entry sprite table and commits it only at vertical blank, so a frame never tears. In each horizontal blank it scans the live table for sprites that intersect the next display line. It then publishes a compact list of up to `MAX_ACTIVE` slots, each with sprite id, x position and sprite row, for the sprite controller to fetch and draw.

## Interface

- `NUM_SPRITES`, 20: table entries, each 24 bits at `gl_input[24*i+23:24*i]`.
- `MAX_ACTIVE`, 8: output slots per line.
- `SPRITE_H`, 32: sprite height in rows; every sprite is 32x32.
- `V_ACTIVE`, 480: visible lines.
- `V_TOTAL`, 525: total lines per frame.

Ports:

- `clk`  in  1: system clock, 50 MHz.
- `reset_n`  in  1: asynchronous, active-low reset.
- `gl_input`  in  512: packed sprite table. Bits [511:480] are ignored.
- `write`  in  1: one-cycle strobe that captures `gl_input` into the pending table.
- `vcount`  in  10: line currently being displayed.
- `hblank_start`  in  1: one-cycle pulse at the start of horizontal blank of line `vcount`.
- `vblank_start`  in  1: one-cycle pulse at the start of vertical blank.
- `slot_valid`  out  `MAX_ACTIVE`: bit k set means slot k holds a sprite.
- `slot_id`  out  4*`MAX_ACTIVE`: sprite id for each slot.
- `slot_x`  out  10*`MAX_ACTIVE`: left x coordinate for each slot.
- `slot_row`  out  5*`MAX_ACTIVE`: row within the sprite, 0..31.
- `list_ready`  out  1: one-cycle pulse when a new slot list is published.
- `overflow`  out  1: more than `MAX_ACTIVE` hits on the published line.
- `busy`  out  1: high while the scheduler is not in IDLE.

## Operation

- Entry format: [23:20] id, [19:10] x, [9:0] y (top row). An id of 0 means the entry is disabled.
- Tables:
  - `write` loads the pending table and sets `pending`.
  - A `vblank_start` pulse while `pending` is set raises `commit_req`.
  - On the first cycle the FSM is in IDLE with `commit_req` set, the pending table is copied to the live table, and `pending` and `commit_req` are cleared.
- If `write` and the commit copy occur in the same cycle, the copy uses the old pending contents. The new data lands in pending and `pending` stays 1.
- The scan reads only the live table.
- FSM states are IDLE, SCAN and PUBLISH.
- IDLE → SCAN on `hblank_start`:
  - target = 0 if `vcount` == `V_TOTAL`-1, otherwise `vcount`+1.
  - The entry index and hit count are cleared.
- If target >= `V_ACTIVE`, the FSM goes IDLE → PUBLISH directly and publishes an empty list.
- SCAN tests one entry per cycle, index 0..`NUM_SPRITES`-1.
  - Hit: id != 0, y <= target, and (target − y) < `SPRITE_H`. Compute in 11-bit unsigned arithmetic; no wrap across frame top.
  - On a hit with count < `MAX_ACTIVE`: store {id, x, target−y[4:0]} in working slot[count] and increment count.
  - On a hit with count == `MAX_ACTIVE`: set working overflow and drop the entry.
  - Slots fill in ascending table-index order; lower index has higher priority.
- SCAN → PUBLISH after index `NUM_SPRITES`-1.
- PUBLISH:
  - Copy the working list to the output registers.
  - `slot_valid` = (1<<count)−1.
  - Drive `overflow` from the working flag.
  - Pulse `list_ready` and return to IDLE.
- `hblank_start` while not in IDLE is ignored. It does not restart the scan.
- Outputs hold their values until the next PUBLISH.

## Timing

- `hblank_start` sampled at cycle 0; SCAN occupies cycles 1..20; PUBLISH at cycle 21.
- `slot_*`, `overflow` and `list_ready` are registered and visible at cycle 22. Total latency is 22 cycles, well inside the 320-cycle hblank.
- Skipped scan (target >= `V_ACTIVE`): PUBLISH at cycle 1, outputs at cycle 2.
- `busy` is high from cycle 1 through the PUBLISH cycle.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - Both tables are cleared to all-zero, which disables every entry.
  - `pending` and `commit_req` are cleared to 0.
  - All outputs are 0.
  - An in-flight scan is discarded and `list_ready` does not fire.
- A commit never occurs mid-scan; it is deferred until IDLE.

## Structure

- Package `sprite_sched_pkg` holds:
  - `sprite_entry_t`, a packed struct {id[3:0], x[9:0], y[9:0]}.
  - `slot_t`, a packed struct {id, x, row[4:0]}.
  - `sched_state_t`, an enum {IDLE, SCAN, PUBLISH}.
  - Default constants `NUM_SPRITES`, `MAX_ACTIVE`, `SPRITE_H`, `V_ACTIVE` and `V_TOTAL`.
- Sub-module `sprite_hit_test`: combinational; takes an entry and target and returns hit and row. It is instantiated once and shared by the sequential scan.

## Test plan

- Reset, then write entry 0 = {id 1, x 100, y 50}, then `vblank_start`, then `hblank_start` with `vcount`=60:
  - At cycle 22: `list_ready`, `slot_valid`=8'h01, slot0 = {1, 100, row 11}.
- Boundary rows, same entry:
  - `vcount`=48 (target 49): empty list.
  - `vcount`=49 (target 50): row 0.
  - `vcount`=80 (target 81): row 31.
  - `vcount`=81 (target 82): empty list.
- Overflow: entries 0..9 all {id 2, y 100}, `vcount`=110:
  - `slot_valid`=8'hFF, slots hold entries 0..7, `overflow`=1.
  - Entries 8 and 9 are absent.
- Shadowing: commit {id 1, y 50}, then write y=200 without `vblank_start`:
  - Scan at target 60 still hits.
  - After `vblank_start`, target 60 misses and target 210 hits.
- Wrap and blank:
  - `vcount`=524: target 0, and an entry with y=0 hits at row 0.
  - `vcount`=479: target 480, empty list at cycle 2.
- Robustness:
  - Second `hblank_start` at cycle 5 is ignored; the list appears once at cycle 22.
  - `reset_n` low at cycle 10: outputs 0, no `list_ready`, entry disabled after release.
